// File: rtl/vecmac_pkg.sv
// vecmac_pkg: shared types and constants for the vecmac multiply scheduler.
//   state_t      scheduler FSM states
//   ELEM_W       operand element width (int8)
//   PROD_W       multiplier product width (int16)
//   ACC_W_DEF    default accumulator width
//   sat_max/min  saturation limits for a w-bit two's-complement accumulator,
//                returned in the low w bits of a 64-bit word
package vecmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  localparam int ELEM_W    = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_W_DEF = 24;

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Low w bits of ~max are 1 followed by zeros, i.e. the most negative value.
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/vecmac_acc.sv
// vecmac_acc: registered dot-product accumulator.
// Adds the sign-extended product on add_en; clr has priority and zeroes the
// sum and the sticky saturation flag.
// Build option: define VECMAC_SAT_EN for a saturating add with a sticky sat
// flag; otherwise the add wraps modulo 2^ACC_W and sat is tied 0.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   clr            clear sum and sat flag
//   add_en         accumulate p this cycle
//   p              signed product (PROD_W)
//   acc            running sum (ACC_W, two's complement)
//   sat            saturation occurred since last clear
module vecmac_acc
  import vecmac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [PROD_W-1:0] p,
  output logic [ACC_W-1:0]  acc,
  output logic              sat
);

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] acc_nxt;

  assign p_ext = {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};

`ifdef VECMAC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] sum_w;
  logic           ovf;

  // One guard bit: overflow when the top two bits of the widened sum differ.
  assign sum_w   = {acc[ACC_W-1], acc} + {p_ext[ACC_W-1], p_ext};
  assign ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign acc_nxt = ovf ? (sum_w[ACC_W] ? SAT_MIN : SAT_MAX) : sum_w[ACC_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat <= 1'b0;
    end else if (clr) begin
      sat <= 1'b0;
    end else if (add_en && ovf) begin
      sat <= 1'b1;
    end
  end
`else
  assign acc_nxt = acc + p_ext;
  assign sat     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/vecmac_mul_sched.sv
// vecmac_mul_sched: issues streamed int8 (a,b) pairs to a shared multi-cycle
// multiplier and accumulates the products into a signed dot product that is
// presented on a valid/ready output.
// Build option: VECMAC_SAT_EN selects a saturating accumulator (see vecmac_acc).
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   in_valid/in_ready, in_a, in_b,   element pair input; in_last closes vector
//   in_last
//   mul_start, mul_a, mul_b          one-cycle start and registered operands
//   mul_done, mul_p                  multiplier completion and product
//   out_valid/out_ready, out_acc,    result handshake, sum, element count,
//   out_count, out_sat               saturation flag
//   busy                             FSM not in IDLE
//   err_timeout                      one-cycle pulse when the multiplier times out
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for the next pair
// S_ISSUE  | mul_start high for one cycle
// S_WAIT   | waiting for mul_done, timeout down-counter running
// S_ACCUM  | add captured product, decide whether the vector closes
// S_OUTPUT | result presented, held until out_ready
module vecmac_mul_sched
  import vecmac_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_a,
  input  logic [ELEM_W-1:0] in_b,
  input  logic              in_last,
  output logic              mul_start,
  output logic [ELEM_W-1:0] mul_a,
  output logic [ELEM_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output logic              busy,
  output logic              err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic              last_q;
  logic [PROD_W-1:0] p_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic [TMO_W-1:0]  tmo;
  logic              tmo_expire;
  logic              acc_clr;
  logic              acc_add;

  assign count_inc  = count + CNT_W'(1);
  // tmo counts down from TIMEOUT-1, so expiry lands on the TIMEOUT-th WAIT cycle.
  assign tmo_expire = (state == S_WAIT) && !mul_done && (tmo == '0);
  assign acc_clr    = tmo_expire || ((state == S_OUTPUT) && out_ready);
  assign acc_add    = (state == S_ACCUM);
  assign busy       = (state != S_IDLE);
  assign out_count  = count;

  vecmac_acc #(.ACC_W(ACC_W)) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .add_en  (acc_add),
    .p       (p_q),
    .acc     (out_acc),
    .sat     (out_sat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      last_q      <= 1'b0;
      p_q         <= '0;
      count       <= '0;
      tmo         <= '0;
      out_valid   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      mul_start   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            last_q    <= in_last;
            in_ready  <= 1'b0;
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            // in_ready rises one cycle after reset release.
            in_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          tmo   <= TMO_W'(TIMEOUT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            p_q   <= mul_p;
            state <= S_ACCUM;
          end else if (tmo == '0) begin
            err_timeout <= 1'b1;
            count       <= '0;
            in_ready    <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmo <= tmo - TMO_W'(1);
          end
        end
        S_ACCUM: begin
          count <= count_inc;
          if (last_q || (count_inc == CNT_W'(MAX_LEN))) begin
            out_valid <= 1'b1;
            state     <= S_OUTPUT;
          end else begin
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vecmac_mul_sched.sv
// tb_vecmac_mul_sched: scoreboard bench for vecmac_mul_sched.
// A behavioural multiplier answers mul_start; a reference model sums a*b per
// vector with plain integer arithmetic (wrap or clamp, per VECMAC_SAT_EN) and
// queues the expected result; a monitor pops and compares on each handshake.
// ACC_W is set to 17 so wrap/saturation is reachable within MAX_LEN.
module tb_vecmac_mul_sched;

  localparam int ACC_W   = 17;
  localparam int MAX_LEN = 256;
  localparam int CNT_W   = 9;
  localparam int TIMEOUT = 64;

  localparam longint MODV = longint'(1) << ACC_W;
  localparam longint SMAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (ACC_W - 1));

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             in_last = 1'b0;
  logic             mul_start;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             mul_done = 1'b0;
  logic [15:0]      mul_p = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             busy;
  logic             err_timeout;

  vecmac_mul_sched #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count),
    .out_sat(out_sat), .busy(busy), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    longint acc;
    int     cnt;
    bit     sat;
  } exp_t;
  exp_t sbq[$];

  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_sat = 0;

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 0;
  endtask

  task automatic model_add(input int sa, input int sb, input bit last);
    longint s;
    exp_t   e;
    s = m_acc + longint'(sa * sb);
`ifdef VECMAC_SAT_EN
    if (s > SMAX) begin
      s = SMAX;
      m_sat = 1;
    end else if (s < SMIN) begin
      s = SMIN;
      m_sat = 1;
    end
`else
    s = ((s % MODV) + MODV) % MODV;
    if (s > SMAX) s = s - MODV;
`endif
    m_acc = s;
    m_cnt++;
    if (last || m_cnt == MAX_LEN) begin
      e.acc = m_acc;
      e.cnt = m_cnt;
      e.sat = m_sat;
      sbq.push_back(e);
      model_clear();
    end
  endtask

  // ---------------- behavioural multiplier ----------------
  int  mul_lat = 4;
  bit  mul_rand_lat = 0;
  bit  mul_withhold = 0;
  bit  mul_busy = 0;
  int  done_cyc = 0;
  int  lat_now;
  logic signed [7:0]  ma, mb;
  logic signed [15:0] prod;

  initial forever begin
    @(negedge clk);
    if (reset_n && mul_start) begin
      ma = mul_a;
      mb = mul_b;
      if (mul_withhold) begin
        mul_withhold = 0;
      end else begin
        mul_busy = 1;
        lat_now = mul_rand_lat ? int'($urandom_range(1, 8)) : mul_lat;
        repeat (lat_now) @(posedge clk);
        #2;
        prod     = ma * mb;
        mul_p    = prod;
        mul_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk);
        #2;
        mul_done = 1'b0;
        mul_p    = 16'($urandom);
        mul_busy = 0;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  bit hold_rdy = 0;
  bit rand_rdy = 0;
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // ---------------- monitor ----------------
  int n_accepts = 0, n_starts = 0, n_err = 0;
  int accept_cyc = 0, start_cyc = 0, err_cyc = 0, ov_rise_cyc = 0;
  longint last_acc = 0;
  int     last_cnt = 0;
  bit     last_sat = 0;
  logic prev_valid = 0, prev_hs = 0, prev_start = 0, prev_sat = 0;
  logic [ACC_W-1:0] prev_acc = '0;
  logic [CNT_W-1:0] prev_cnt = '0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset_n) begin
      prev_valid = 0;
      prev_hs    = 0;
      prev_start = 0;
    end else begin
      if (in_valid && in_ready) begin
        n_accepts++;
        accept_cyc = cyc;
      end
      if (mul_start) begin
        n_starts++;
        start_cyc = cyc;
        check("mul_start_single_cycle", prev_start, 0);
      end
      if (err_timeout) begin
        n_err++;
        err_cyc = cyc;
      end
      if (prev_hs) begin
        check("in_ready_after_pop", in_ready, 1);
        check("out_valid_after_pop", out_valid, 0);
      end
      if (prev_valid && !prev_hs) begin
        check("hold_valid", out_valid, 1);
        check("hold_acc", out_acc, prev_acc);
        check("hold_count", out_count, prev_cnt);
        check("hold_sat", out_sat, prev_sat);
      end
      if (out_valid) begin
        check("in_ready_low_in_output", in_ready, 0);
        check("busy_in_output", busy, 1);
        if (!prev_valid) ov_rise_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        last_acc = longint'($signed(out_acc));
        last_cnt = int'(out_count);
        last_sat = out_sat;
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got acc %0d count %0d, none expected", last_acc, last_cnt);
        end else begin
          e = sbq.pop_front();
          check("out_acc", last_acc, e.acc);
          check("out_count", last_cnt, e.cnt);
          check("out_sat", last_sat, e.sat);
        end
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_start = mul_start;
      prev_acc   = out_acc;
      prev_cnt   = out_count;
      prev_sat   = out_sat;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit last,
                           input bit withhold, input bit use_model);
    bit ok;
    ok = 0;
    @(posedge clk);
    #2;
    mul_withhold = withhold;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready never rose for pair %0d,%0d", a, b);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    if (use_model) model_add(int'($signed(a)), int'($signed(b)), last);
  endtask

  task automatic send_vec(input int len, input bit use_last);
    for (int i = 0; i < len; i++)
      send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                use_last && (i == len - 1), 1'b0, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10000 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_drain: %0d results outstanding", name, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check(name, longint'({in_ready, mul_start, mul_a, mul_b, out_valid, out_acc,
                          out_count, out_sat, busy, err_timeout}), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, e0, k;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vector: (3,4),(-2,5),(7,-1) -> -5, count 3, one start per element.
    s0 = n_starts;
    send_pair(8'd3, 8'd4, 0, 0, 1);
    send_pair(8'hFE, 8'd5, 0, 0, 1);
    send_pair(8'd7, 8'hFF, 1, 0, 1);
    drain("vec3");
    check("vec3_acc", last_acc, -5);
    check("vec3_count", last_cnt, 3);
    check("vec3_starts", n_starts - s0, 3);

    // Single element (-128,-128): latency checks.
    send_pair(8'h80, 8'h80, 1, 0, 1);
    drain("single");
    check("single_acc", last_acc, 16384);
    check("single_count", last_cnt, 1);
    check("accept_to_start", start_cyc - accept_cyc, 1);
    check("done_to_out_valid", ov_rise_cyc - done_cyc, 2);

    // Backpressure: out_ready held low for 10 cycles.
    hold_rdy = 1;
    send_pair(8'd5, 8'd6, 1, 0, 1);
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    check("held_out_valid", out_valid, 1);
    check("held_in_ready", in_ready, 0);
    check("held_out_acc", longint'($signed(out_acc)), 30);
    hold_rdy = 0;
    drain("hold");

    // Timeout: element 2 never completes.
    e0 = n_err;
    send_pair(8'd10, 8'd10, 0, 0, 1);
    send_pair(8'd20, 8'd20, 0, 1, 0);
    k = 0;
    while (n_err == e0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("timeout_pulses", n_err - e0, 1);
    check("timeout_delay", err_cyc - start_cyc, TIMEOUT + 1);
    @(negedge clk);
    check("timeout_one_cycle", err_timeout, 0);
    check("timeout_no_output", out_valid, 0);
    model_clear();
    send_pair(8'd1, 8'd1, 1, 0, 1);
    drain("after_timeout");
    check("after_timeout_acc", last_acc, 1);

    // 5 x (127,127) at ACC_W=17.
    for (int i = 0; i < 5; i++) send_pair(8'd127, 8'd127, i == 4, 0, 1);
    drain("overflow");
`ifdef VECMAC_SAT_EN
    check("overflow_acc", last_acc, 65535);
    check("overflow_sat", last_sat, 1);
`else
    check("overflow_acc", last_acc, -50427);
    check("overflow_sat", last_sat, 0);
`endif

    // Reset while in WAIT, late mul_done afterwards.
    mul_lat = 20;
    send_pair(8'd9, 8'd9, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    model_clear();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    k = 0;
    while (mul_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("late_done_ignored_busy", busy, 0);
    check("late_done_ignored_valid", out_valid, 0);
    mul_lat = 4;
    send_pair(8'd2, 8'd3, 1, 0, 1);
    drain("after_reset");
    check("after_reset_acc", last_acc, 6);

    // Randomized vectors with random latency and backpressure.
    mul_rand_lat = 1;
    rand_rdy = 1;
    for (int v = 0; v < 30; v++) send_vec(int'($urandom_range(1, 6)), 1'b1);
    drain("random");

    // Vector without in_last closes at MAX_LEN, then a short vector follows.
    send_vec(MAX_LEN, 1'b0);
    send_vec(2, 1'b1);
    drain("max_len");
    check("max_len_tail_count", last_cnt, 2);

    check("starts_vs_accepts", n_starts, n_accepts);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vecmac_mul_sched.md
Name: vecmac_mul_sched

Overview:
- Sequences a shared multi-cycle int8 multiplier (start/done handshake) to compute a signed dot product over a streamed vector of (a,b) element pairs.
- Accepts one element pair at a time, issues it to the multiplier, and accumulates the 16-bit product.
- Presents the final sum on a valid/ready output. Sits between the vector operand buffer and the multiplier datapath in the vecmac top level.

Parameters:
- ACC_W, 24, accumulator/result width in bits (≥17).
- MAX_LEN, 256, maximum elements per vector; the vector is forced to close at this count.
- CNT_W, 9, element counter width; must hold MAX_LEN.
- TIMEOUT, 64, cycles allowed in WAIT for mul_done before the vector is aborted.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  element pair valid
- in_ready  out  1  scheduler can accept a pair
- in_a  in  8  signed operand a
- in_b  in  8  signed operand b
- in_last  in  1  marks final element of the vector
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a  out  8  registered operand a to multiplier
- mul_b  out  8  registered operand b to multiplier
- mul_done  in  1  multiplier finished; mul_p valid this cycle
- mul_p  in  16  signed product
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  signed dot-product result
- out_count  out  CNT_W  number of elements accumulated
- out_sat  out  1  saturation occurred in this vector (0 unless macro)
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  one-cycle pulse on multiplier timeout

Behaviour:
- Reset: all outputs 0; acc=0, count=0; state IDLE.
- Reset asserted mid-operation aborts everything. mul_start drops immediately; any in-flight product is discarded.
- FSM states: IDLE, ISSUE, WAIT, ACCUM, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register a, b and last into mul_a/mul_b/last_q, then go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly one cycle; go to WAIT.
  - Accept-to-start latency is 1 cycle.
- WAIT:
  - mul_start=0. Sample mul_p on the first cycle mul_done=1, then go to ACCUM.
  - mul_done is ignored in all states other than WAIT.
  - Timeout counter clears on WAIT entry. If it reaches TIMEOUT without mul_done: pulse err_timeout, clear acc/count/sat, return to IDLE. No output is produced.
- ACCUM:
  - acc <= acc + sign_extend(mul_p); count <= count+1.
  - If last_q, or count+1==MAX_LEN, go to OUTPUT. Otherwise go to IDLE.
- OUTPUT:
  - out_valid=1; out_acc, out_count and out_sat are held stable until out_ready.
  - On out_valid&out_ready: clear acc/count/sat and go to IDLE.
  - in_ready=0 throughout OUTPUT (no overlap).
- A 1-element vector (in_last on the first pair) is legal: out_count=1.
- Arithmetic: two's complement. Without the optional feature, the sum wraps modulo 2^ACC_W.
- in_a/in_b are don't-care when in_valid=0.

Optional Feature:
- Macro: VECMAC_SAT_EN.
- Defined: the ACCUM add saturates to +(2^(ACC_W-1)-1) / -2^(ACC_W-1), and out_sat becomes a sticky flag for the current vector.
- Undefined: the add wraps and out_sat is tied 0.

Decomposition:
- Package vecmac_pkg holds:
  - FSM state enum.
  - Element width 8 and product width 16 constants.
  - Default ACC_W.
  - Saturation max/min constant functions.
- One sub-module, vecmac_acc: the registered accumulator with clear, add-enable, wrap/sat logic (macro-gated) and the sticky sat flag.

Test Plan:
- Vector (3,4),(-2,5),(7,-1 last), multiplier done 4 cycles after start → out_acc=-5 (hex FFFFFB), out_count=3; mul_start exactly one cycle per element.
- Single element (-128,-128,last) → out_acc=16384, out_count=1; latency: start 1 cycle after accept, out_valid 1 cycle after ACCUM.
- Hold out_ready=0 for 10 cycles → out_valid/out_acc stable, in_ready=0; release → in_ready=1 next cycle, acc cleared.
- Withhold mul_done on element 2 → err_timeout pulse after TIMEOUT=64 cycles, no out_valid; next vector (1,1 last) gives out_acc=1.
- ACC_W=17, 5× (127,127) → undefined macro: wrapped value 80645 mod 2^17 as signed = -50427; VECMAC_SAT_EN: out_acc=65535, out_sat=1.
- reset_n low while in WAIT → all outputs 0 asynchronously. A late mul_done after release is ignored, and a fresh vector (2,3 last) gives 6.
